// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: FSM state codes (also the
// db_estado debug encoding), the one-hot LED constants and small helpers.
package jogador_automatico_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PULSA_JOGAR = 4'h1,
      OBSERVA     = 4'h2,
      SILENCIO    = 4'h3,
      APERTA      = 4'h4,
      SOLTA       = 4'h5,
      PROX_RODADA = 4'h6,
      FIM         = 4'hF
   } estado_t;

   localparam logic [3:0] LED_APAGADO = 4'b0000;
   localparam logic [3:0] LED_0       = 4'b0001;
   localparam logic [3:0] LED_1       = 4'b0010;
   localparam logic [3:0] LED_2       = 4'b0100;
   localparam logic [3:0] LED_3       = 4'b1000;

   function automatic logic eh_one_hot(input logic [3:0] v);
      return (v == LED_0) || (v == LED_1) || (v == LED_2) || (v == LED_3);
   endfunction

   // Wrong-button injection: move the press to the next LED position.
   function automatic logic [3:0] rotaciona(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/jogador_automatico_contador.sv
// contador_m: modulo-M up counter with synchronous clear (zera), enable
// (conta) and a terminal-count flag (fim) raised while q equals M-1.
module contador_m #(
   parameter int M = 50,
   parameter int N = 7
) (
   input  logic         clock,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] q,
   output logic         fim
);

   always_ff @(posedge clock) begin
      if (zera)
         q <= '0;
      else if (conta)
         q <= (q == N'(M - 1)) ? '0 : q + N'(1);
   end

   assign fim = (q == N'(M - 1));

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: watches the LED sequence shown each
// round, stores it, and replays it on the buttons with fixed press/gap timing.
module jogador_automatico
   import jogador_automatico_pkg::*;
#(
   parameter int MAX_RODADAS = 16,
   parameter int T_PRESS     = 50,
   parameter int T_GAP       = 50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       erro_en,
   input  logic [3:0] erro_rodada,
   input  logic [3:0] leds,
   input  logic       ganhou,
   input  logic       perdeu,
   input  logic       pronto,
   output logic       jogar,
   output logic [3:0] botoes,
   output logic       venceu,
   output logic       falhou,
   output logic       fim,
   output logic [3:0] db_estado,
   output logic [3:0] db_rodada,
   output logic [3:0] db_indice
);

   localparam int  T_MAX       = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
   localparam int  TW          = $clog2(T_MAX) + 1;
   localparam int  AW          = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
   localparam bit  PRESS_E_MAX = (T_PRESS >= T_GAP);

   estado_t         estado;
   estado_t         prox;
   logic [AW-1:0]   rodada;
   logic [AW-1:0]   indice;
   logic [AW-1:0]   prox_indice;
   logic            cheio;
   logic [3:0]      leds_ant;
   logic [3:0]      buffer [MAX_RODADAS];
   logic [3:0]      prox_botao;
   logic            grava;
   logic            completo;
   logic            encerra;
   logic [TW-1:0]   timer_q;
   logic            timer_fim;
   logic            timer_zera;
   logic            timer_conta;
   logic            fim_press;
   logic            fim_gap;

   contador_m #(
      .M(T_MAX),
      .N(TW)
   ) u_timer (
      .clock(clock),
      .zera (timer_zera),
      .conta(timer_conta),
      .q    (timer_q),
      .fim  (timer_fim)
   );

   assign fim_press = PRESS_E_MAX ? timer_fim : (timer_q == TW'(T_PRESS - 1));
   assign fim_gap   = PRESS_E_MAX ? (timer_q == TW'(T_GAP - 1)) : timer_fim;

   assign grava = (estado == OBSERVA) && (leds_ant == LED_APAGADO) && eh_one_hot(leds);

   // The last round fills every slot, so a saturated index is flagged by cheio.
   assign completo = cheio || ((AW+1)'(indice) == (AW+1)'(rodada) + (AW+1)'(1));

   // FIM is left out so iniciar can restart while the game still shows its result.
   assign encerra = (ganhou || perdeu || pronto) &&
                    (estado != INICIAL) && (estado != PULSA_JOGAR) && (estado != FIM);

   always_comb begin
      prox_indice = (estado == SILENCIO) ? '0 : indice + AW'(1);
      prox_botao  = buffer[prox_indice];
      if (erro_en && (int'(rodada) == int'(erro_rodada)) && (prox_indice == rodada))
         prox_botao = rotaciona(buffer[prox_indice]);
   end

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:     if (iniciar) prox = PULSA_JOGAR;
         PULSA_JOGAR: prox = OBSERVA;
         OBSERVA:     if ((leds == LED_APAGADO) && completo) prox = SILENCIO;
         SILENCIO:    if ((leds == LED_APAGADO) && fim_gap) prox = APERTA;
         APERTA:      if (fim_press) prox = SOLTA;
         SOLTA:       if (fim_gap) prox = (indice == rodada) ? PROX_RODADA : APERTA;
         PROX_RODADA: prox = (int'(rodada) + 1 == MAX_RODADAS) ? FIM : OBSERVA;
         FIM:         if (iniciar) prox = PULSA_JOGAR;
         default:     prox = INICIAL;
      endcase
      if (encerra)
         prox = FIM;
   end

   assign timer_conta = (estado == SILENCIO) || (estado == APERTA) || (estado == SOLTA);
   assign timer_zera  = reset || (prox != estado) ||
                        ((estado == SILENCIO) && (leds != LED_APAGADO));

   always_ff @(posedge clock) begin
      if (grava)
         buffer[indice] <= leds;
   end

   // Main FSM; every output is registered and updated alongside the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= INICIAL;
         jogar    <= 1'b0;
         botoes   <= LED_APAGADO;
         venceu   <= 1'b0;
         falhou   <= 1'b0;
         fim      <= 1'b0;
         rodada   <= '0;
         indice   <= '0;
         cheio    <= 1'b0;
         leds_ant <= LED_APAGADO;
      end else begin
         estado   <= prox;
         leds_ant <= leds;
         jogar    <= (prox == PULSA_JOGAR);
         case (estado)
            INICIAL: botoes <= LED_APAGADO;
            PULSA_JOGAR: begin
               rodada <= '0;
               indice <= '0;
               cheio  <= 1'b0;
            end
            OBSERVA: begin
               if (grava) begin
                  if (int'(indice) == MAX_RODADAS - 1)
                     cheio <= 1'b1;
                  else
                     indice <= indice + AW'(1);
               end
            end
            SILENCIO, SOLTA: begin
               if (prox == APERTA) begin
                  indice <= prox_indice;
                  botoes <= prox_botao;
               end
            end
            APERTA: if (prox == SOLTA) botoes <= LED_APAGADO;
            PROX_RODADA: begin
               if (prox == FIM) begin
                  fim    <= 1'b1;
                  falhou <= 1'b1;
                  venceu <= 1'b0;
               end else begin
                  rodada <= rodada + AW'(1);
                  indice <= '0;
                  cheio  <= 1'b0;
               end
            end
            FIM: begin
               if (prox == PULSA_JOGAR) begin
                  fim    <= 1'b0;
                  venceu <= 1'b0;
                  falhou <= 1'b0;
               end
            end
            default: botoes <= LED_APAGADO;
         endcase
         if (encerra) begin
            botoes <= LED_APAGADO;
            venceu <= ganhou;
            falhou <= perdeu;
            fim    <= 1'b1;
         end
      end
   end

   assign db_estado = estado;
   assign db_rodada = 4'(rodada);
   assign db_indice = 4'(indice);

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: a small game model shows LED
// sequences, queues the expected presses and judges the replayed buttons.
module tb_jogador_automatico;
   import jogador_automatico_pkg::*;

   localparam int MAX_RODADAS = 4;
   localparam int T_PRESS     = 3;
   localparam int T_GAP       = 4;
   localparam int T_LED       = 3;
   localparam int T_ENTRE     = 2;
   localparam int LIMITE      = 300;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       erro_en;
   logic [3:0] erro_rodada;
   logic [3:0] leds;
   logic       ganhou;
   logic       perdeu;
   logic       pronto;
   logic       jogar;
   logic [3:0] botoes;
   logic       venceu;
   logic       falhou;
   logic       fim;
   logic [3:0] db_estado;
   logic [3:0] db_rodada;
   logic [3:0] db_indice;

   int         n_comparados = 0;
   int         n_falhas     = 0;
   logic [3:0] esperado_q [$];
   logic [3:0] seq [MAX_RODADAS];

   jogador_automatico #(
      .MAX_RODADAS(MAX_RODADAS),
      .T_PRESS    (T_PRESS),
      .T_GAP      (T_GAP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .erro_en    (erro_en),
      .erro_rodada(erro_rodada),
      .leds       (leds),
      .ganhou     (ganhou),
      .perdeu     (perdeu),
      .pronto     (pronto),
      .jogar      (jogar),
      .botoes     (botoes),
      .venceu     (venceu),
      .falhou     (falhou),
      .fim        (fim),
      .db_estado  (db_estado),
      .db_rodada  (db_rodada),
      .db_indice  (db_indice)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [7:0] observado,
                               input logic [7:0] esperado);
      n_comparados++;
      assert (observado === esperado)
      else begin
         n_falhas++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observado, esperado);
      end
   endtask

   // Game model: shows round r's LEDs and queues what the player must press.
   task automatic apply_stimulus(input int r, input bit com_ruido);
      logic [3:0] v;
      for (int i = 0; i <= r; i++) begin
         if (com_ruido && i == r) begin
            leds = 4'b0110;
            repeat (T_LED) @(negedge clock);
            leds = 4'b0000;
            repeat (T_ENTRE) @(negedge clock);
         end
         v    = seq[i];
         leds = v;
         if (erro_en && r == int'(erro_rodada) && i == r)
            esperado_q.push_back({v[2:0], v[3]});
         else
            esperado_q.push_back(v);
         repeat (T_LED) @(negedge clock);
         leds = 4'b0000;
         if (i < r) repeat (T_ENTRE) @(negedge clock);
      end
      @(negedge clock);
   endtask

   task automatic collect(input int n, output bit ok);
      int         espera;
      int         largura;
      logic [3:0] v;
      logic [3:0] e;
      ok = 1'b1;
      for (int k = 0; k < n; k++) begin
         espera = 0;
         while (botoes == 4'b0000 && espera < LIMITE) begin
            @(negedge clock);
            espera++;
         end
         check_output("press_seen", {7'b0, botoes != 4'b0000}, 8'd1);
         if (k > 0) check_output("gap_width", 8'(espera), 8'(T_GAP));
         v = botoes;
         check_output("one_hot", 8'($countones(v)), 8'd1);
         e = (esperado_q.size() > 0) ? esperado_q.pop_front() : 4'b0000;
         check_output("press_value", {4'b0, v}, {4'b0, e});
         if (v != seq[k]) ok = 1'b0;
         largura = 0;
         while (botoes == v && largura < LIMITE) begin
            largura++;
            @(negedge clock);
         end
         check_output("press_width", 8'(largura), 8'(T_PRESS));
      end
   endtask

   task automatic wait_estado(input logic [3:0] e);
      int n;
      n = 0;
      while (db_estado !== e && n < LIMITE) begin
         @(negedge clock);
         n++;
      end
      check_output("wait_state", {4'b0, db_estado}, {4'b0, e});
   endtask

   initial begin
      bit ok;
      int cnt;

      reset       = 1'b1;
      iniciar     = 1'b0;
      erro_en     = 1'b0;
      erro_rodada = 4'd0;
      leds        = 4'b0000;
      ganhou      = 1'b0;
      perdeu      = 1'b0;
      pronto      = 1'b0;
      repeat (3) @(negedge clock);
      check_output("rst_botoes", {4'b0, botoes}, 8'h00);
      check_output("rst_jogar", {7'b0, jogar}, 8'h00);
      check_output("rst_fim", {7'b0, fim}, 8'h00);
      check_output("rst_venceu", {7'b0, venceu}, 8'h00);
      check_output("rst_falhou", {7'b0, falhou}, 8'h00);
      check_output("rst_estado", {4'b0, db_estado}, 8'(INICIAL));
      check_output("rst_rodada", {4'b0, db_rodada}, 8'h00);
      check_output("rst_indice", {4'b0, db_indice}, 8'h00);
      reset = 1'b0;
      @(negedge clock);
      check_output("idle_estado", {4'b0, db_estado}, 8'(INICIAL));

      $display("[TB] game A: full win, noise in round 1");
      seq = '{LED_1, LED_3, LED_0, LED_2};
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      check_output("jogar_pulse", {7'b0, jogar}, 8'h01);
      check_output("pulsa_estado", {4'b0, db_estado}, 8'(PULSA_JOGAR));
      @(negedge clock);
      check_output("jogar_low", {7'b0, jogar}, 8'h00);
      check_output("observa_estado", {4'b0, db_estado}, 8'(OBSERVA));
      for (int r = 0; r < MAX_RODADAS; r++) begin
         if (r > 0) wait_estado(OBSERVA);
         check_output("round_index", {4'b0, db_rodada}, 8'(r));
         apply_stimulus(r, r == 1);
         collect(r + 1, ok);
         check_output("round_ok", {7'b0, ok}, 8'h01);
      end
      ganhou = 1'b1;
      @(negedge clock);
      ganhou = 1'b0;
      check_output("win_fim", {7'b0, fim}, 8'h01);
      check_output("win_venceu", {7'b0, venceu}, 8'h01);
      check_output("win_falhou", {7'b0, falhou}, 8'h00);
      check_output("win_estado", {4'b0, db_estado}, 8'(FIM));
      check_output("win_botoes", {4'b0, botoes}, 8'h00);
      repeat (3) @(negedge clock);
      check_output("win_hold_fim", {7'b0, fim}, 8'h01);
      check_output("win_hold_venceu", {7'b0, venceu}, 8'h01);

      $display("[TB] game B: wrong press injected in round 2");
      erro_en     = 1'b1;
      erro_rodada = 4'd2;
      seq = '{LED_0, LED_2, LED_3, LED_1};
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      check_output("restart_jogar", {7'b0, jogar}, 8'h01);
      check_output("restart_fim", {7'b0, fim}, 8'h00);
      check_output("restart_venceu", {7'b0, venceu}, 8'h00);
      @(negedge clock);
      for (int r = 0; r < 3; r++) begin
         if (r > 0) wait_estado(OBSERVA);
         apply_stimulus(r, 1'b0);
         collect(r + 1, ok);
         check_output("inj_round_ok", {7'b0, ok}, (r == 2) ? 8'h00 : 8'h01);
      end
      perdeu = 1'b1;
      @(negedge clock);
      perdeu = 1'b0;
      check_output("lose_fim", {7'b0, fim}, 8'h01);
      check_output("lose_falhou", {7'b0, falhou}, 8'h01);
      check_output("lose_venceu", {7'b0, venceu}, 8'h00);
      check_output("lose_botoes", {4'b0, botoes}, 8'h00);
      check_output("queue_empty", 8'(esperado_q.size()), 8'h00);
      erro_en = 1'b0;

      $display("[TB] game C: silence glitch, game never signals an end");
      seq = '{LED_2, LED_1, LED_0, LED_3};
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      @(negedge clock);
      leds = seq[0];
      esperado_q.push_back(seq[0]);
      repeat (T_LED) @(negedge clock);
      leds = 4'b0000;
      @(negedge clock);
      check_output("silencio_estado", {4'b0, db_estado}, 8'(SILENCIO));
      repeat (2) @(negedge clock);
      leds = LED_0;
      @(negedge clock);
      leds = 4'b0000;
      cnt = 0;
      while (botoes == 4'b0000 && cnt < LIMITE) begin
         @(negedge clock);
         cnt++;
      end
      check_output("glitch_delay", 8'(cnt), 8'(T_GAP));
      collect(1, ok);
      check_output("glitch_round_ok", {7'b0, ok}, 8'h01);
      for (int r = 1; r < MAX_RODADAS; r++) begin
         wait_estado(OBSERVA);
         apply_stimulus(r, 1'b0);
         collect(r + 1, ok);
         check_output("c_round_ok", {7'b0, ok}, 8'h01);
      end
      cnt = 0;
      while (fim !== 1'b1 && cnt < LIMITE) begin
         @(negedge clock);
         cnt++;
      end
      check_output("timeout_fim", {7'b0, fim}, 8'h01);
      check_output("timeout_falhou", {7'b0, falhou}, 8'h01);
      check_output("timeout_venceu", {7'b0, venceu}, 8'h00);
      check_output("timeout_estado", {4'b0, db_estado}, 8'(FIM));

      $display("[TB] game D: reset while a button is held");
      seq = '{LED_2, LED_0, LED_1, LED_3};
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      @(negedge clock);
      apply_stimulus(0, 1'b0);
      cnt = 0;
      while (botoes == 4'b0000 && cnt < LIMITE) begin
         @(negedge clock);
         cnt++;
      end
      check_output("pre_reset_botoes", {4'b0, botoes}, {4'b0, LED_2});
      check_output("pre_reset_estado", {4'b0, db_estado}, 8'(APERTA));
      esperado_q.delete();
      reset = 1'b1;
      @(negedge clock);
      check_output("mid_reset_botoes", {4'b0, botoes}, 8'h00);
      check_output("mid_reset_estado", {4'b0, db_estado}, 8'(INICIAL));
      check_output("mid_reset_fim", {7'b0, fim}, 8'h00);
      check_output("mid_reset_jogar", {7'b0, jogar}, 8'h00);
      check_output("mid_reset_indice", {4'b0, db_indice}, 8'h00);
      check_output("mid_reset_rodada", {4'b0, db_rodada}, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_falhas);
      $finish;
   end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter MAX_RODADAS, default 16: rounds per game; sets sequence-buffer depth.
REQ-002 Parameter T_PRESS, default 50: cycles each button is held active.
REQ-003 Parameter T_GAP, default 50: cycles of all-zero botoes between presses, and of silence before replay starts.
REQ-004 clock  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 iniciar  in  1  one-cycle request to start an automatic game.
REQ-007 erro_en, erro_rodada[3:0]  in  1/4  inject one wrong press on the last element of round erro_rodada.
REQ-008 leds  in  4  LED outputs of the game circuit (observed sequence).
REQ-009 ganhou, perdeu, pronto  in  1 each  game-end indications.
REQ-010 jogar  out  1  one-cycle start pulse to the game circuit.
REQ-011 botoes  out  4  one-hot button drive to the game circuit; 0000 when idle.
REQ-012 venceu, falhou, fim  out  1 each  registered result flags.
REQ-013 db_estado[3:0], db_rodada[3:0], db_indice[3:0]  out  debug state code, current round, buffer index.

Function
REQ-014 States: INICIAL, PULSA_JOGAR, OBSERVA, SILENCIO, APERTA, SOLTA, PROX_RODADA, FIM; each has a fixed 4-bit db_estado code.
REQ-015 INICIAL: botoes=0000, jogar=0; iniciar=1 -> PULSA_JOGAR.
REQ-016 PULSA_JOGAR: jogar=1 for exactly one cycle, rodada:=0, indice:=0, then OBSERVA.
REQ-017 OBSERVA: a transition of leds from 0000 to a one-hot value (0001/0010/0100/1000) writes that value to buffer[indice] and increments indice on the same edge.
REQ-018 A non-one-hot nonzero leds value is ignored (no write, no increment).
REQ-019 When indice equals rodada+1 and leds=0000 -> SILENCIO; timer clears on entry.
REQ-020 SILENCIO: after T_GAP consecutive cycles of leds=0000, indice:=0 -> APERTA; any nonzero leds restarts the timer.
REQ-021 APERTA: botoes=buffer[indice] for T_PRESS cycles -> SOLTA.
REQ-022 Injection: when erro_en=1 and rodada=erro_rodada, the press at indice=rodada drives the value rotated left by one (0001->0010, 1000->0001).
REQ-023 SOLTA: botoes=0000 for T_GAP cycles; then indice=rodada -> PROX_RODADA, else indice++ -> APERTA.
REQ-024 PROX_RODADA: rodada++, indice:=0 -> OBSERVA; if rodada+1 reaches MAX_RODADAS -> FIM with falhou=1.
REQ-025 ganhou, perdeu or pronto =1 in any state other than INICIAL/PULSA_JOGAR -> FIM next cycle, overriding every other transition; botoes:=0000 that edge.
REQ-026 FIM: fim=1, venceu:=ganhou, falhou:=perdeu (or per REQ-024), held until reset or iniciar; iniciar -> PULSA_JOGAR, flags cleared.
REQ-027 Buffer: MAX_RODADAS x 4 bits, written only in OBSERVA; indice saturates at MAX_RODADAS-1 (no wrap).
REQ-028 Timer: one counter of width clog2(max(T_PRESS,T_GAP))+1, cleared on every state change.
REQ-029 botoes is registered; never more than one bit high.

Reset
REQ-030 reset=1 at any cycle, including mid-press: next state INICIAL, botoes=0000, jogar=0, venceu=falhou=fim=0, rodada=indice=timer=0.
REQ-031 Buffer contents need not be cleared; they are never read before being rewritten.

Structure
REQ-032 State codes and the one-hot LED constants live in the shared include file used by the game's control units.
REQ-033 The timer is a sub-module instance of the existing contador_m (modulo counter with zera/conta/fim); everything else is in one module.

Verification
REQ-034 Bench pairs this block with circuito_exp7: iniciar pulse, no injection -> jogar one cycle later, 16 rounds replayed, ganhou=1, venceu=1, fim=1.
REQ-035 erro_en=1, erro_rodada=2 -> rounds 0-1 pass, third press of round 2 differs, perdeu=1 -> falhou=1, venceu=0.
REQ-036 Model drives leds 0010, 0000, 0110, 1000 in round 1 -> buffer holds 0010,1000; 0110 ignored; replay 0010 then 1000, each T_PRESS cycles.
REQ-037 reset asserted during APERTA with botoes=0100 -> next cycle botoes=0000, db_estado=INICIAL, fim=0.
REQ-038 Model never asserts ganhou/perdeu -> after MAX_RODADAS rounds FIM with falhou=1, venceu=0.
REQ-039 Glitch: leds pulses nonzero 3 cycles into SILENCIO -> replay delayed to T_GAP cycles after that pulse ends.
